// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared state type, defaults and round-robin grant helper
//
// Used by adder_share_arb and adder_cin_dp.
//   state_t   : IDLE / ADD / RESP sequencer states
//   DEF_NREQ  : default requester count
//   DEF_W     : default operand width
//   BLK_W     : width of one adder block in the shared datapath
//   rr_grant  : first requesting index at or after ptr, wrapping at nreq

package adder_share_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 32;
    localparam int BLK_W    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request vector and pointer are widened to the 8-requester maximum so one
    // function serves every NREQ; the caller truncates the returned index.
    function automatic int unsigned rr_grant(input logic [7:0]  req,
                                             input logic [2:0]  ptr,
                                             input int unsigned nreq);
        int unsigned g;
        int unsigned idx;
        logic        hit;
        g   = 0;
        hit = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = (32'(ptr) + k) % nreq;
            if (!hit && (k < nreq) && req[idx[2:0]]) begin
                g   = idx;
                hit = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/adder_cin_dp.sv
// rtl/adder_cin_dp.sv - combinational W-bit adder with carry-in, W+1-bit result
//
// Ports:
//   a, b  in  W    operands (treated as unsigned)
//   cin   in  1    carry-in
//   sum   out W+1  a + b + cin; bit W is the carry-out
//
// Built from ripple-chained BLK_W-bit adder blocks; the bits left over when W
// is not a multiple of BLK_W are finished with single full-adder cells.

module adder_cin_dp
    import adder_share_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W:0]   sum
);

    localparam int NB = W / BLK_W;
    localparam int NR = W % BLK_W;

    logic [NB:0] blk_c;
    logic [NR:0] fa_c;

    assign blk_c[0] = cin;

    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
        logic [BLK_W:0] blk_s;
        assign blk_s = {1'b0, a[gi*BLK_W +: BLK_W]}
                     + {1'b0, b[gi*BLK_W +: BLK_W]}
                     + {{BLK_W{1'b0}}, blk_c[gi]};
        assign sum[gi*BLK_W +: BLK_W] = blk_s[BLK_W-1:0];
        assign blk_c[gi+1]            = blk_s[BLK_W];
    end

    assign fa_c[0] = blk_c[NB];

    for (genvar gj = 0; gj < NR; gj++) begin : g_fa
        localparam int B = NB*BLK_W + gj;
        assign sum[B]     = a[B] ^ b[B] ^ fa_c[gj];
        assign fa_c[gj+1] = (a[B] & b[B]) | (fa_c[gj] & (a[B] ^ b[B]));
    end

    assign sum[W] = fa_c[NR];

endmodule

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin arbiter sharing one adder among NREQ requesters
//
// Ports:
//   clk, rst     in   clock (rising edge), asynchronous active-high reset
//   req_valid    in   NREQ     per-requester operand valid
//   req_ready    out  NREQ     one-hot accept, only in IDLE
//   req_x, req_y in   NREQ*W   operands, requester i at [i*W +: W]
//   req_chain    in   NREQ     chain flag (only with ADDER_ARB_CHAIN_EN)
//   rsp_valid    out  1        result valid (registered)
//   rsp_ready    in   1        result consumer ready
//   rsp_id       out  clog2    requester owning rsp_sum
//   rsp_sum      out  W+1      x + y + cin
//   busy         out  1        sequencer not in IDLE
//
// Optional feature macro: ADDER_ARB_CHAIN_EN enables carry chaining with a
// per-requester lock so multi-word sums can be built from successive ops.

module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_x,
    input  logic [NREQ*W-1:0]        req_y,
`ifdef ADDER_ARB_CHAIN_EN
    input  logic [NREQ-1:0]          req_chain,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W:0]               rsp_sum,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_next;
    logic [IW-1:0] grant;
    logic          grant_ok;
    logic          accept;
    logic [IW-1:0] g_r;
    logic [W-1:0]  x_r;
    logic [W-1:0]  y_r;
    logic [W:0]    sum_r;
    logic [W:0]    dp_sum;
    logic          cin;
    logic          rsp_valid_r;

`ifdef ADDER_ARB_CHAIN_EN
    logic          chain_r;
    logic          c_r;
    logic          lock_v;
    logic [IW-1:0] lock_id;

    // While a chain is open only its owner may be granted, so no other op
    // can slip between the low and high words.
    always_comb begin
        grant    = IW'(rr_grant(8'(req_valid), 3'(rr_ptr), NREQ));
        grant_ok = |req_valid;
        if (lock_v) begin
            grant    = lock_id;
            grant_ok = req_valid[lock_id];
        end
    end

    // c_r is zero whenever no chain is open, so it can feed cin directly.
    assign cin = c_r;
`else
    always_comb begin
        grant    = IW'(rr_grant(8'(req_valid), 3'(rr_ptr), NREQ));
        grant_ok = |req_valid;
    end

    assign cin = 1'b0;
`endif

    adder_cin_dp #(
        .W (W)
    ) u_dp (
        .a   (x_r),
        .b   (y_r),
        .cin (cin),
        .sum (dp_sum)
    );

    assign rr_next = (g_r == IW'(NREQ - 1)) ? '0 : g_r + 1'b1;

    always_comb begin
        state_n   = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_n          = ADD;
                end
            end
            ADD: begin
                state_n = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            g_r         <= '0;
            x_r         <= '0;
            y_r         <= '0;
            sum_r       <= '0;
            rsp_valid_r <= 1'b0;
`ifdef ADDER_ARB_CHAIN_EN
            chain_r     <= 1'b0;
            c_r         <= 1'b0;
            lock_v      <= 1'b0;
            lock_id     <= '0;
`endif
        end else begin
            state       <= state_n;
            rsp_valid_r <= (state_n == RESP);

            if (accept) begin
                x_r <= req_x[grant*W +: W];
                y_r <= req_y[grant*W +: W];
                g_r <= grant;
`ifdef ADDER_ARB_CHAIN_EN
                chain_r <= req_chain[grant];
`endif
            end

            if (state == ADD) begin
                sum_r <= dp_sum;
`ifdef ADDER_ARB_CHAIN_EN
                if (chain_r) begin
                    c_r     <= dp_sum[W];
                    lock_v  <= 1'b1;
                    lock_id <= g_r;
                end
`endif
            end

            if ((state == RESP) && rsp_ready) begin
`ifdef ADDER_ARB_CHAIN_EN
                // The pointer only moves once the chain closes, so the
                // owner's turn covers every word of its multi-word sum.
                if (!chain_r) begin
                    c_r    <= 1'b0;
                    lock_v <= 1'b0;
                    rr_ptr <= rr_next;
                end
`else
                rr_ptr <= rr_next;
`endif
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = g_r;
    assign rsp_sum   = sum_r;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - self-checking bench for adder_share_arb

`timescale 1ns/1ps

module tb_adder_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
`ifdef ADDER_ARB_CHAIN_EN
    logic [NREQ-1:0]   req_chain;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W:0]        rsp_sum;
    logic              busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W:0]    sum;
    } exp_t;

    typedef struct {
        int         id;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   sum;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    always #5 clk = ~clk;

    adder_share_arb #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
`ifdef ADDER_ARB_CHAIN_EN
        .req_chain (req_chain),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard consumer: every completed response must match the oldest
    // expectation pushed at its accept.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                report_timeout("rsp_unexpected");
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                check("rsp_sum", 64'(rsp_sum), 64'(mon_e.sum));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
        req_valid[i]     = v;
        req_x[i*W +: W]  = x;
        req_y[i*W +: W]  = y;
    endtask

    task automatic push_exp(input int id, input logic [W:0] sum);
        exp_t e;
        e.id  = IW'(id);
        e.sum = sum;
        sb.push_back(e);
    endtask

    // Called just after a posedge; returns at the negedge where req_ready rose.
    task automatic wait_grant(output int waited);
        waited = 0;
        @(negedge clk);
        while (req_ready == '0 && waited < 20) begin
            tick();
            @(negedge clk);
            waited++;
        end
        if (req_ready == '0) report_timeout("grant_timeout");
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            report_timeout("drain_timeout");
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;
`ifdef ADDER_ARB_CHAIN_EN
        req_chain = '0;
`endif
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int mp;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        vecs[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
        vecs[1] = '{0, 32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};
        vecs[2] = '{1, 32'h1234_5678, 32'h9ABC_DEF0, 33'h0_ACF1_3568};
        vecs[3] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
        vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
        vecs[5] = '{0, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
        vecs[6] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 33'h0_8000_0000};
        vecs[7] = '{3, 32'hDEAD_BEEF, 32'h2152_4111, 33'h1_0000_0000};

        do_reset();
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_id", 64'(rsp_id), 64'h0);
        check("rst_rsp_sum", 64'(rsp_sum), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        tick();

        // Single-requester table: grant, 2-cycle latency, sum.
        for (int v = 0; v < 8; v++) begin
            set_req(vecs[v].id, 1'b1, vecs[v].x, vecs[v].y);
            wait_grant(waited);
            check("vec_grant", 64'(req_ready), 64'(1 << vecs[v].id));
            push_exp(vecs[v].id, vecs[v].sum);
            tick();
            set_req(vecs[v].id, 1'b0, '0, '0);
            @(negedge clk);
            check("vec_lat_n1", 64'(rsp_valid), 64'h0);
            check("vec_busy_add", 64'(busy), 64'h1);
            tick();
            @(negedge clk);
            check("vec_lat_n2", 64'(rsp_valid), 64'h1);
            drain();
        end

        // All four requesting continuously: 0,1,2,3,0 with back-to-back accepts.
        do_reset();
        mp = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, W'(i) * 32'h1111_1111, 32'hF000_0000 + W'(i));
        for (int k = 0; k < 5; k++) begin
            wait_grant(waited);
            if (k > 0) check("rr_b2b_wait", 64'(waited), 64'h0);
            check("rr_grant", 64'(req_ready), 64'(1 << mp));
            rx = W'(mp) * 32'h1111_1111;
            ry = 32'hF000_0000 + W'(mp);
            push_exp(mp, {1'b0, rx} + {1'b0, ry});
            tick();
            if (k == 4) req_valid = '0;
            @(negedge clk);
            check("rr_lat_n1", 64'(rsp_valid), 64'h0);
            tick();
            @(negedge clk);
            check("rr_lat_n2", 64'(rsp_valid), 64'h1);
            tick();
            mp = (mp + 1) % NREQ;
        end
        drain();

        // Response stall: outputs hold, requests ignored, completes when ready rises.
        do_reset();
        set_req(1, 1'b1, 32'd5, 32'd6);
        wait_grant(waited);
        check("stall_grant", 64'(req_ready), 64'h2);
        push_exp(1, 33'd11);
        tick();
        set_req(1, 1'b0, '0, '0);
        set_req(2, 1'b1, 32'd7, 32'd8);
        rsp_ready = 1'b0;
        @(negedge clk);
        tick();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_valid", 64'(rsp_valid), 64'h1);
            check("stall_sum", 64'(rsp_sum), 64'd11);
            check("stall_id", 64'(rsp_id), 64'd1);
            check("stall_req_ready", 64'(req_ready), 64'h0);
            check("stall_busy", 64'(busy), 64'h1);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 64'(rsp_valid), 64'h1);
        tick();
        @(negedge clk);
        check("stall_done_valid", 64'(rsp_valid), 64'h0);
        check("stall_next_grant", 64'(req_ready), 64'h4);
        push_exp(2, 33'd15);
        tick();
        set_req(2, 1'b0, '0, '0);
        drain();

        // Reset during ADD: op discarded, pointer back to 0.
        set_req(2, 1'b1, 32'd1, 32'd2);
        wait_grant(waited);
        check("mid_grant", 64'(req_ready), 64'h4);
        push_exp(2, 33'd3);
        tick();
        set_req(2, 1'b0, '0, '0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rsp_valid", 64'(rsp_valid), 64'h0);
        check("mid_busy", 64'(busy), 64'h0);
        check("mid_rsp_sum", 64'(rsp_sum), 64'h0);
        tick();
        rst = 1'b0;
        waited = 0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            if (rsp_valid) waited++;
            tick();
        end
        check("mid_no_stale_rsp", 64'(waited), 64'h0);
        set_req(1, 1'b1, 32'd3, 32'd4);
        set_req(3, 1'b1, 32'hDEAD_BEEF, 32'h2152_4111);
        wait_grant(waited);
        check("mid_ptr_zero_grant", 64'(req_ready), 64'h2);
        push_exp(1, 33'd7);
        tick();
        set_req(1, 1'b0, '0, '0);
        wait_grant(waited);
        check("mid_grant3", 64'(req_ready), 64'h8);
        push_exp(3, 33'h1_0000_0000);
        tick();
        set_req(3, 1'b0, '0, '0);
        drain();

`ifdef ADDER_ARB_CHAIN_EN
        // 64-bit add from requester 1 while requester 0 competes.
        do_reset();
        set_req(0, 1'b1, 32'd0, 32'd0);
        wait_grant(waited);
        push_exp(0, 33'd0);
        tick();
        set_req(0, 1'b0, '0, '0);
        drain();
        set_req(0, 1'b1, 32'd10, 32'd20);
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1);
        req_chain[1] = 1'b1;
        wait_grant(waited);
        check("chain_lo_grant", 64'(req_ready), 64'h2);
        push_exp(1, 33'h1_0000_0000);
        tick();
        set_req(1, 1'b1, 32'd0, 32'd0);
        req_chain[1] = 1'b0;
        wait_grant(waited);
        check("chain_hi_grant", 64'(req_ready), 64'h2);
        push_exp(1, 33'd1);
        tick();
        set_req(1, 1'b0, '0, '0);
        wait_grant(waited);
        check("chain_after_grant", 64'(req_ready), 64'h1);
        push_exp(0, 33'd30);
        tick();
        set_req(0, 1'b0, '0, '0);
        drain();
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
